// File: rtl/coded_nibble_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : coded_nibble_serializer_if
//  Description : Bundle of the nibble-capture and serial-line signals of the
//                coded nibble serializer.
//                  S0..S3, ready  : encoded nibble and capture request
//                  tx             : serial line (idles high)
//                  busy           : frame in flight
//                  hold_full      : holding register occupied
//                  done           : last cycle of a frame's stop bit
//                  overrun        : sticky nibble-dropped flag
//                master drives the nibble side, slave is the serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface coded_nibble_serializer_if;
    logic S0;
    logic S1;
    logic S2;
    logic S3;
    logic ready;
    logic tx;
    logic busy;
    logic hold_full;
    logic done;
    logic overrun;

    modport master (
        output S0, S1, S2, S3, ready,
        input  tx, busy, hold_full, done, overrun
    );

    modport slave (
        input  S0, S1, S2, S3, ready,
        output tx, busy, hold_full, done, overrun
    );
endinterface
`default_nettype wire

// File: rtl/coded_nibble_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : coded_nibble_serializer
//  Description : Sends an encoded nibble S0..S3 as a serial frame on tx:
//                start(0), S0, S1, S2, S3, [even parity], stop(1), each bit
//                held for BIT_CYCLES clocks. A one-entry holding register
//                accepts a second nibble while a frame is in flight; any
//                further nibble is dropped and flagged on the sticky overrun.
//  Ports       : clk       - system clock, rising edge
//                reset     - synchronous, active-high
//                bus       - coded_nibble_serializer_if.slave
//                            (S0..S3, ready in; tx, busy, hold_full,
//                             done, overrun out)
//  Parameters  : BIT_CYCLES - clocks per serial bit, 1..255
//  Macros      : CODSER_PARITY_EN - insert an even-parity bit before stop
//  Revision    : 1.0 - initial release
// ============================================================================
module coded_nibble_serializer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    coded_nibble_serializer_if.slave  bus
);

    localparam int              TW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [TW-1:0]   c_BIT_LAST = TW'(BIT_CYCLES - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_STOP   = 3'd3;
`ifdef CODSER_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd4;
`endif

    logic [2:0]    state_q,     state_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic [1:0]    idx_q,       idx_d;
    logic [3:0]    shift_q,     shift_d;
    logic [3:0]    hold_q,      hold_d;
    logic          hold_full_q, hold_full_d;
    logic          tx_q,        tx_d;
    logic          overrun_q,   overrun_d;

    logic [3:0]    w_nibble;
    logic          w_bit_end;
    logic          w_frame_end;

    assign w_nibble    = {bus.S3, bus.S2, bus.S1, bus.S0};
    assign w_bit_end   = (timer_q == c_BIT_LAST);
    assign w_frame_end = (state_q == c_STOP) && w_bit_end;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;
        overrun_d   = overrun_q;

        // Timer restarts at every bit boundary and stays parked while idle,
        // so a frame started from IDLE always begins with timer = 0.
        timer_d = (state_q == c_IDLE || w_bit_end) ? '0 : timer_q + 1'b1;

        case (state_q)
            c_IDLE: begin
                tx_d = 1'b1;
                if (bus.ready) begin
                    shift_d = w_nibble;
                    state_d = c_START;
                    tx_d    = 1'b0;
                end
            end
            c_START: begin
                if (w_bit_end) begin
                    state_d = c_DATA;
                    idx_d   = 2'd0;
                    tx_d    = shift_q[0];
                end
            end
            c_DATA: begin
                if (w_bit_end) begin
                    if (idx_q == 2'd3) begin
`ifdef CODSER_PARITY_EN
                        state_d = c_PARITY;
                        tx_d    = ^shift_q;
`else
                        state_d = c_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 2'd1;
                        tx_d  = shift_q[idx_q + 2'd1];
                    end
                end
            end
`ifdef CODSER_PARITY_EN
            c_PARITY: begin
                if (w_bit_end) begin
                    state_d = c_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            c_STOP: begin
                if (w_bit_end) begin
                    if (hold_full_q) begin
                        // Pending nibble goes out with no idle gap.
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = c_START;
                        tx_d        = 1'b0;
                    end else if (bus.ready) begin
                        shift_d = w_nibble;
                        state_d = c_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = c_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = c_IDLE;
                idx_d   = 2'd0;
                tx_d    = 1'b1;
            end
        endcase

        // Capture while a frame is in flight. On the end-of-frame edge the
        // hold is being emptied into the shift register, so a simultaneous
        // request refills it instead of overrunning; with an empty hold the
        // request was already loaded straight into the shift register above.
        if (bus.ready && state_q != c_IDLE) begin
            if (w_frame_end) begin
                if (hold_full_q) begin
                    hold_d      = w_nibble;
                    hold_full_d = 1'b1;
                end
            end else if (!hold_full_q) begin
                hold_d      = w_nibble;
                hold_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= c_IDLE;
            timer_q     <= '0;
            idx_q       <= 2'd0;
            shift_q     <= 4'd0;
            hold_q      <= 4'd0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.tx        = tx_q;
    assign bus.busy      = (state_q != c_IDLE);
    assign bus.hold_full = hold_full_q;
    assign bus.done      = w_frame_end;
    assign bus.overrun   = overrun_q;

endmodule
`default_nettype wire
